// File: rtl/blake2_core_arbiter_if.sv
// rtl/blake2_core_arbiter_if.sv - command/digest channel between a BLAKE2 message controller and a hash core
interface blake2_core_arbiter_if #(
    parameter int BLOCK_WIDTH  = 1024,
    parameter int DATA_LENGTH  = 128,
    parameter int DIGEST_WIDTH = 512
) ();
    logic                    init;
    logic                    next;
    logic                    fin;
    logic [BLOCK_WIDTH-1:0]  block;
    logic [DATA_LENGTH-1:0]  length;
    logic                    ready;
    logic                    digest_valid;
    logic [DIGEST_WIDTH-1:0] digest;

    // master issues commands and receives ready/digest; slave is the side that executes them
    modport master (
        output init, next, fin, block, length,
        input  ready, digest_valid, digest
    );

    modport slave (
        input  init, next, fin, block, length,
        output ready, digest_valid, digest
    );
endinterface

// File: rtl/blake2_core_arbiter.sv
// rtl/blake2_core_arbiter.sv - shares one BLAKE2 core between two message controllers, one whole message at a time
module blake2_core_arbiter #(
    parameter int BLOCK_WIDTH  = 1024,
    parameter int DATA_LENGTH  = 128,
    parameter int DIGEST_WIDTH = 512
) (
    input  logic                         clk,
    input  logic                         reset_n,
    blake2_core_arbiter_if.slave         req0,
    blake2_core_arbiter_if.slave         req1,
    blake2_core_arbiter_if.master        core,
    output logic                         owner,
    output logic                         busy,
    output logic                         protocol_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_WAIT_DIG,
        S_ISSUE_PEND
    } state_t;

    state_t                  state_q;
    logic                    owner_q;
    logic                    prio_q;
    logic                    pend_valid_q;
    logic                    pend_id_q;
    logic [BLOCK_WIDTH-1:0]  pend_block_q;
    logic [DATA_LENGTH-1:0]  pend_length_q;
    logic [1:0]              hold_q;
    logic                    core_init_q;
    logic                    core_next_q;
    logic                    core_final_q;
    logic [BLOCK_WIDTH-1:0]  core_block_q;
    logic [DATA_LENGTH-1:0]  core_length_q;
    logic [DIGEST_WIDTH-1:0] digest_q;
    logic [1:0]              dv_q;
    logic                    err_q;

    logic [1:0]              r_init;
    logic [1:0]              r_next;
    logic [1:0]              r_fin;
    logic [1:0]              r_any;
    logic [1:0]              r_bad;
    logic [1:0]              r_rdy;
    logic [BLOCK_WIDTH-1:0]  r_block  [2];
    logic [DATA_LENGTH-1:0]  r_length [2];

    logic                    avail;
    logic [1:0]              acc;
    logic                    collide;
    logic                    cmd_err;
    logic                    win;

    assign r_init      = {req1.init, req0.init};
    assign r_next      = {req1.next, req0.next};
    assign r_fin       = {req1.fin,  req0.fin};
    assign r_any       = r_init | r_next | r_fin;
    assign r_bad       = (r_init & r_next) | (r_init & r_fin) | (r_next & r_fin);
    assign r_block[0]  = req0.block;
    assign r_block[1]  = req1.block;
    assign r_length[0] = req0.length;
    assign r_length[1] = req1.length;

    // the hold masks the window before the core has had a chance to drop its ready
    assign avail = core.ready & (hold_q == 2'd0);

    always_comb begin
        r_rdy = 2'b00;
        case (state_q)
            S_IDLE:  r_rdy = {avail, avail};
            S_BUSY:  r_rdy[owner_q] = avail;
            default: r_rdy = 2'b00;
        endcase
    end

    always_comb begin
        acc     = 2'b00;
        collide = 1'b0;
        cmd_err = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (r_any[i]) begin
                if (r_bad[i] || !r_rdy[i]) begin
                    cmd_err = 1'b1;
                end else begin
                    case (state_q)
                        S_IDLE: begin
                            if (r_init[i]) acc[i] = 1'b1;
                            else           cmd_err = 1'b1;
                        end
                        S_BUSY: begin
                            if (r_init[i]) cmd_err = 1'b1;
                            else           acc[i] = 1'b1;
                        end
                        default: cmd_err = 1'b1;
                    endcase
                end
            end
        end
        // simultaneous inits: the priority holder wins, the other is parked, not flagged
        if (acc == 2'b11) begin
            collide = 1'b1;
            acc     = prio_q ? 2'b10 : 2'b01;
        end
    end

    assign win = acc[1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            owner_q       <= 1'b0;
            prio_q        <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_id_q     <= 1'b0;
            pend_block_q  <= '0;
            pend_length_q <= '0;
            hold_q        <= 2'd0;
            core_init_q   <= 1'b0;
            core_next_q   <= 1'b0;
            core_final_q  <= 1'b0;
            core_block_q  <= '0;
            core_length_q <= '0;
            digest_q      <= '0;
            dv_q          <= 2'b00;
            err_q         <= 1'b0;
        end else begin
            core_init_q  <= 1'b0;
            core_next_q  <= 1'b0;
            core_final_q <= 1'b0;
            dv_q         <= 2'b00;

            if (hold_q != 2'd0) hold_q <= hold_q - 2'd1;
            if (cmd_err) err_q <= 1'b1;
            if (core.digest_valid && state_q != S_WAIT_DIG) err_q <= 1'b1;

            if (|acc) begin
                core_init_q   <= r_init[win];
                core_next_q   <= r_next[win];
                core_final_q  <= r_fin[win];
                core_block_q  <= r_block[win];
                core_length_q <= r_length[win];
                owner_q       <= win;
                hold_q        <= 2'd2;
            end

            case (state_q)
                S_IDLE: begin
                    if (|acc) begin
                        state_q <= S_BUSY;
                        if (collide) begin
                            pend_valid_q  <= 1'b1;
                            pend_id_q     <= ~win;
                            pend_block_q  <= r_block[~win];
                            pend_length_q <= r_length[~win];
                        end
                    end
                end
                S_BUSY: begin
                    if ((|acc) && r_fin[win]) state_q <= S_WAIT_DIG;
                end
                S_WAIT_DIG: begin
                    if (core.digest_valid) begin
                        digest_q      <= core.digest;
                        dv_q[owner_q] <= 1'b1;
                        prio_q        <= ~owner_q;
                        state_q       <= pend_valid_q ? S_ISSUE_PEND : S_IDLE;
                    end
                end
                S_ISSUE_PEND: begin
                    if (core.ready) begin
                        core_init_q   <= 1'b1;
                        core_block_q  <= pend_block_q;
                        core_length_q <= pend_length_q;
                        owner_q       <= pend_id_q;
                        pend_valid_q  <= 1'b0;
                        hold_q        <= 2'd2;
                        state_q       <= S_BUSY;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req0.ready        = r_rdy[0];
    assign req1.ready        = r_rdy[1];
    assign req0.digest_valid = dv_q[0];
    assign req1.digest_valid = dv_q[1];
    assign req0.digest       = digest_q;
    assign req1.digest       = digest_q;

    assign core.init   = core_init_q;
    assign core.next   = core_next_q;
    assign core.fin    = core_final_q;
    assign core.block  = core_block_q;
    assign core.length = core_length_q;

    assign owner        = owner_q;
    assign busy         = (state_q != S_IDLE);
    assign protocol_err = err_q;

endmodule
